reg_write_arbiter: RTL



---
 rtl/reg_write_arbiter_pkg.sv | 22 ++
 rtl/reg_write_arbiter_if.sv | 31 +++
 rtl/reg_write_arbiter_rr_arbiter3.sv | 34 +++
 rtl/reg_write_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-write arbiter slice.
// Imported by the interface, the round-robin grant block and the top.
package reg_write_arbiter_pkg;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int SRCW = 2;

  localparam logic [SRCW-1:0] SRC_CLEAR = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Next requester index in the fixed 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] rrInc(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Request/write-port bundle between requesters (master) and the arbiter (slave).
interface reg_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int AW   = 3
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_start;
  logic               busy;
  logic               clr_done;
  logic               we3;
  logic [AW-1:0]      wa3;
  logic [DW-1:0]      wd3;
  logic [1:0]         src_id;
  logic               zero_drop;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, busy, clr_done, we3, wa3, wd3, src_id, zero_drop
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, busy, clr_done, we3, wa3, wd3, src_id, zero_drop
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter3.sv
// Three-way round-robin grant: searches rr, rr+1, rr+2 (mod 3) for the first
// valid requester and returns a one-hot grant plus its index.
module rr_arbiter3
  import reg_write_arbiter_pkg::*;
(
  input  logic [2:0] valid_i,
  input  logic [1:0] rr_i,
  input  logic       enable_i,
  output logic [2:0] grant_o,
  output logic [1:0] idx_o
);

  logic       found;
  logic [1:0] cand;

  // An out-of-range pointer is folded to 0 so the search never indexes past bit 2.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = (rr_i > 2'd2) ? 2'd0 : rr_i;
    if (enable_i) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && valid_i[cand]) begin
          grant_o[cand] = 1'b1;
          idx_o         = cand;
          found         = 1'b1;
        end
        cand = rrInc(cand);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-bank write arbiter: round-robin merge of three write requesters
// onto one registered write port, plus a sequencer that zeroes registers 1..7.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = reg_write_arbiter_pkg::NREQ,
  parameter int DW   = reg_write_arbiter_pkg::DW,
  parameter int AW   = reg_write_arbiter_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  reg_write_arbiter_if.slave  bus_io
);

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = {AW{1'b1}};

  state_e          state_q, state_d;
  logic [1:0]      rrPtr_q, rrPtr_d;
  logic [AW-1:0]   clrCnt_q, clrCnt_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic [SRCW-1:0] src_q, src_d;
  logic            zeroDrop_q, zeroDrop_d;
  logic            clrDone_q, clrDone_d;

  logic            arbEnable;
  logic            clrIssue;
  logic            busyFlag;
  logic [2:0]      grant;
  logic [1:0]      grantIdx;
  logic            accept;
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selData;

  rr_arbiter3 u_rr_arbiter3 (
    .valid_i  (bus_io.req_valid),
    .rr_i     (rrPtr_q),
    .enable_i (arbEnable),
    .grant_o  (grant),
    .idx_o    (grantIdx)
  );

  assign accept  = |(grant & bus_io.req_valid);
  assign selAddr = bus_io.req_addr[int'(grantIdx)*AW +: AW];
  assign selData = bus_io.req_data[int'(grantIdx)*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CLEAR keeps one tail cycle after the last counter write so busy covers
  // the cycle in which the wa3=7 write (and clr_done) is visible.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus_io.clr_start) state_d = CLEAR;
      CLEAR:   if (clrDone_q)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arbEnable = 1'b0;
    clrIssue  = 1'b0;
    busyFlag  = 1'b0;
    unique case (state_q)
      IDLE:    arbEnable = !bus_io.clr_start;
      CLEAR: begin
        busyFlag = 1'b1;
        clrIssue = !clrDone_q;
      end
      default: ;
    endcase
  end

  // Write-port next values; clear writes and accepted requests are mutually
  // exclusive because the arbiter is disabled throughout CLEAR.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    clrCnt_d   = clrCnt_q;
    we3_d      = 1'b0;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    src_d      = src_q;
    zeroDrop_d = 1'b0;
    clrDone_d  = 1'b0;
    if (clrIssue) begin
      we3_d     = 1'b1;
      wa3_d     = clrCnt_q;
      wd3_d     = '0;
      src_d     = SRC_CLEAR;
      clrDone_d = (clrCnt_q == CNT_LAST);
      clrCnt_d  = (clrCnt_q == CNT_LAST) ? CNT_FIRST : clrCnt_q + AW'(1);
    end else if (accept) begin
      rrPtr_d = rrInc(grantIdx);
      wa3_d   = selAddr;
      wd3_d   = selData;
      src_d   = grantIdx;
      if (selAddr == '0) begin
        zeroDrop_d = 1'b1;
      end else begin
        we3_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q    <= 2'd0;
      clrCnt_q   <= CNT_FIRST;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      src_q      <= '0;
      zeroDrop_q <= 1'b0;
      clrDone_q  <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      clrCnt_q   <= clrCnt_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      src_q      <= src_d;
      zeroDrop_q <= zeroDrop_d;
      clrDone_q  <= clrDone_d;
    end
  end

  assign bus_io.req_ready = grant;
  assign bus_io.busy      = busyFlag;
  assign bus_io.clr_done  = clrDone_q;
  assign bus_io.we3       = we3_q;
  assign bus_io.wa3       = wa3_q;
  assign bus_io.wd3       = wd3_q;
  assign bus_io.src_id    = src_q;
  assign bus_io.zero_drop = zeroDrop_q;

endmodule
